// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus peripheral: register offsets, reset
// defaults, status bit positions and the serial frame state type.
package uart_pkg;

   typedef enum logic [31:0] {
      ADDR_RX_DATA          = 32'd0,
      ADDR_TX_DATA          = 32'd4,
      ADDR_RX_STATE         = 32'd8,
      ADDR_TX_STATE         = 32'd12,
      ADDR_BAUD_RATE        = 32'd16,
      ADDR_BUFFER_CLEAR     = 32'd20,
      ADDR_USE_FLOW_CONTROL = 32'd24
   } uart_addr_e;

   localparam int unsigned DEFAULT_RATE = 5207;
   localparam int unsigned FIFO_DEPTH   = 8;

   localparam int unsigned RX_ERR_BIT   = 5;
   localparam int unsigned RX_AVAIL_BIT = 4;
   localparam int unsigned TX_IDLE_BIT  = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } frame_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Power-of-two byte FIFO with head-of-queue output; a push into a full FIFO
// is only accepted when a pop frees a slot in the same cycle.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int unsigned Depth = FIFO_DEPTH
) (
   input  logic                    clk,
   input  logic                    nReset,
   input  logic                    push,
   input  logic                    pop,
   input  logic                    clear,
   input  logic [7:0]              din,
   output logic [7:0]              dout,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(Depth):0]  count
);
   localparam int unsigned PtrW = $clog2(Depth);
   localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

   logic [7:0]      mem [Depth];
   logic [PtrW-1:0] rd_ptr, wr_ptr;
   logic            do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FullCnt);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or posedge nReset) begin
      if (nReset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PtrW + 1)'(1);
            2'b01:   count <= count - (PtrW + 1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_bus_periph.sv
// Memory-mapped 8N1 UART: bus register slave, RX/TX byte FIFOs, per-frame
// latched baud divisor and optional cts flow control.
module uart_bus_periph
   import uart_pkg::*;
#(
   parameter int unsigned DefaultRate = DEFAULT_RATE,
   parameter int unsigned FifoDepth   = FIFO_DEPTH
) (
   input  logic        clk,
   input  logic        nReset,
   input  logic        rx,
   output logic        tx,
   input  logic        cts,
   output logic        rts,
   input  logic        wen,
   input  logic        ren,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  strobe,
   output logic [31:0] rdata,
   output logic        error,
   output logic        request_stall
);
   localparam int unsigned CntW      = $clog2(FifoDepth) + 1;
   localparam logic [15:0] RateReset = 16'(DefaultRate);

   logic [15:0] rate;
   logic        use_fc, err, avail, clr_q;
   logic        wr_tx_data, wr_baud, wr_clear, wr_fc, abort;
   logic        rd_rx_data, rd_rx_state;
   logic [31:0] rdata_d;
   logic        strobe_unused;

   frame_state_e    rx_state;
   logic            rx_meta, rx_s, rx_prev;
   logic [15:0]     rx_cnt, rx_rate;
   logic [2:0]      rx_bit;
   logic [7:0]      rx_shift;
   logic            rx_done, rx_err;
   logic            rx_full, rx_empty, rx_overflow;
   logic [7:0]      rx_dout;
   logic [CntW-1:0] rx_count;

   frame_state_e    tx_state;
   logic [15:0]     tx_cnt, tx_rate;
   logic [2:0]      tx_bit;
   logic [7:0]      tx_shift;
   logic            tx_start, tx_full, tx_empty, tx_overflow;
   logic [7:0]      tx_dout;
   logic [CntW-1:0] tx_count;

   assign strobe_unused = ^strobe;
   assign request_stall = 1'b0;
   assign rts           = rx_full;

   assign wr_tx_data  = wen && (addr == ADDR_TX_DATA);
   assign wr_baud     = wen && (addr == ADDR_BAUD_RATE);
   assign wr_clear    = wen && (addr == ADDR_BUFFER_CLEAR) && (|wdata);
   assign wr_fc       = wen && (addr == ADDR_USE_FLOW_CONTROL);
   assign abort       = wen && ((addr == ADDR_RX_STATE) || (addr == ADDR_TX_STATE));
   assign rd_rx_data  = ren && (addr == ADDR_RX_DATA);
   assign rd_rx_state = ren && (addr == ADDR_RX_STATE);

   // A frame must not start on the clear cycle: its head byte is being discarded.
   assign tx_start    = (tx_state == S_IDLE) && !tx_empty && (cts || !use_fc)
                        && !abort && !clr_q;
   assign tx_overflow = wr_tx_data && tx_full && !tx_start;
   assign rx_overflow = rx_done && rx_full && !rd_rx_data;

   uart_byte_fifo #(.Depth(FifoDepth)) u_rx_fifo (
      .clk    (clk),
      .nReset (nReset),
      .push   (rx_done),
      .pop    (rd_rx_data),
      .clear  (clr_q),
      .din    (rx_shift),
      .dout   (rx_dout),
      .full   (rx_full),
      .empty  (rx_empty),
      .count  (rx_count)
   );

   uart_byte_fifo #(.Depth(FifoDepth)) u_tx_fifo (
      .clk    (clk),
      .nReset (nReset),
      .push   (wr_tx_data),
      .pop    (tx_start),
      .clear  (clr_q),
      .din    (wdata[7:0]),
      .dout   (tx_dout),
      .full   (tx_full),
      .empty  (tx_empty),
      .count  (tx_count)
   );

   always_comb begin
      rdata_d = '0;
      if (ren) begin
         case (addr)
            ADDR_RX_DATA: rdata_d[7:0] = rx_empty ? 8'h00 : rx_dout;
            ADDR_RX_STATE: begin
               rdata_d[RX_ERR_BIT]   = err;
               rdata_d[RX_AVAIL_BIT] = avail;
               rdata_d[3:0]          = 4'(rx_count);
            end
            ADDR_TX_STATE: begin
               rdata_d[31:16]       = rate;
               rdata_d[TX_IDLE_BIT] = (tx_state == S_IDLE);
               rdata_d[3:0]         = 4'(tx_count);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge nReset) begin
      if (nReset) begin
         rate   <= RateReset;
         use_fc <= 1'b1;
         err    <= 1'b0;
         avail  <= 1'b0;
         error  <= 1'b0;
         clr_q  <= 1'b0;
         rdata  <= '0;
      end else begin
         rdata <= rdata_d;
         clr_q <= wr_clear;
         if (wr_baud) rate <= (wdata[15:0] < 16'd2) ? 16'd2 : wdata[15:0];
         if (wr_fc) use_fc <= |wdata;
         if (rx_done)          avail <= 1'b1;
         else if (rd_rx_data)  avail <= 1'b0;
         if (rx_err)           err <= 1'b1;
         else if (rd_rx_state) err <= 1'b0;
         if (clr_q)                            error <= 1'b0;
         else if (tx_overflow || rx_overflow)  error <= 1'b1;
      end
   end

   // Receiver: rx is double-synchronised; the byte is pushed the cycle after
   // a good stop bit, while rx_shift still holds it.
   always_ff @(posedge clk or posedge nReset) begin
      if (nReset) begin
         rx_meta  <= 1'b1;
         rx_s     <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_rate  <= RateReset;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_done  <= 1'b0;
         rx_err   <= 1'b0;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
         rx_done <= 1'b0;
         rx_err  <= 1'b0;
         if (abort) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
         end else begin
            case (rx_state)
               S_IDLE: begin
                  if (rx_prev && !rx_s) begin
                     rx_state <= S_START;
                     rx_cnt   <= '0;
                     rx_rate  <= rate;
                  end
               end
               S_START: begin
                  if (rx_cnt == (rx_rate >> 1) - 16'd1) begin
                     rx_cnt   <= '0;
                     rx_bit   <= '0;
                     rx_state <= rx_s ? S_IDLE : S_DATA;
                  end else begin
                     rx_cnt <= rx_cnt + 16'd1;
                  end
               end
               S_DATA: begin
                  if (rx_cnt == rx_rate - 16'd1) begin
                     rx_cnt   <= '0;
                     rx_shift <= {rx_s, rx_shift[7:1]};
                     rx_bit   <= rx_bit + 3'd1;
                     if (rx_bit == 3'd7) rx_state <= S_STOP;
                  end else begin
                     rx_cnt <= rx_cnt + 16'd1;
                  end
               end
               S_STOP: begin
                  if (rx_cnt == rx_rate - 16'd1) begin
                     rx_cnt   <= '0;
                     rx_state <= S_IDLE;
                     if (rx_s) rx_done <= 1'b1;
                     else      rx_err  <= 1'b1;
                  end else begin
                     rx_cnt <= rx_cnt + 16'd1;
                  end
               end
               default: rx_state <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge nReset) begin
      if (nReset) begin
         tx_state <= S_IDLE;
         tx       <= 1'b1;
         tx_cnt   <= '0;
         tx_rate  <= RateReset;
         tx_bit   <= '0;
         tx_shift <= '0;
      end else if (abort) begin
         tx_state <= S_IDLE;
         tx       <= 1'b1;
         tx_cnt   <= '0;
      end else begin
         case (tx_state)
            S_IDLE: begin
               if (tx_start) begin
                  tx_state <= S_START;
                  tx       <= 1'b0;
                  tx_cnt   <= '0;
                  tx_rate  <= rate;
                  tx_shift <= tx_dout;
                  tx_bit   <= '0;
               end
            end
            S_START: begin
               if (tx_cnt == tx_rate - 16'd1) begin
                  tx_cnt   <= '0;
                  tx       <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_state <= S_DATA;
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            S_DATA: begin
               if (tx_cnt == tx_rate - 16'd1) begin
                  tx_cnt <= '0;
                  tx_bit <= tx_bit + 3'd1;
                  if (tx_bit == 3'd7) begin
                     tx       <= 1'b1;
                     tx_state <= S_STOP;
                  end else begin
                     tx       <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                  end
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            S_STOP: begin
               if (tx_cnt == tx_rate - 16'd1) begin
                  tx_cnt   <= '0;
                  tx_state <= S_IDLE;
               end else begin
                  tx_cnt <= tx_cnt + 16'd1;
               end
            end
            default: begin
               tx_state <= S_IDLE;
               tx       <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bus_periph.sv
// Directed/randomised bench for uart_bus_periph against a queue-based model
// of the register map, FIFOs and serial frames.
module tb_uart_bus_periph;
   localparam int unsigned DEF_RATE = 5207;

   logic        clk = 1'b0;
   logic        nReset, rx, cts, wen, ren;
   logic [31:0] addr, wdata;
   logic [3:0]  strobe;
   logic        tx, rts, error, request_stall;
   logic [31:0] rdata;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   logic [7:0]  rxq[$];
   logic [7:0]  txq[$];
   logic        m_err, m_avail, m_error, m_fc;
   logic [15:0] m_rate;

   uart_bus_periph #(.DefaultRate(DEF_RATE), .FifoDepth(8)) dut (
      .clk           (clk),
      .nReset        (nReset),
      .rx            (rx),
      .tx            (tx),
      .cts           (cts),
      .rts           (rts),
      .wen           (wen),
      .ren           (ren),
      .addr          (addr),
      .wdata         (wdata),
      .strobe        (strobe),
      .rdata         (rdata),
      .error         (error),
      .request_stall (request_stall)
   );

   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      rxq.delete();
      txq.delete();
      m_err = 0; m_avail = 0; m_error = 0; m_fc = 1;
      m_rate = 16'(DEF_RATE);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk); wen = 1'b1; addr = a; wdata = d;
      @(negedge clk); wen = 1'b0; addr = '0; wdata = '0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk); ren = 1'b1; addr = a;
      @(negedge clk); ren = 1'b0; addr = '0; d = rdata;
   endtask

   task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
      bus_write(a, d);
      case (a)
         32'd4:  if (txq.size() < 8) txq.push_back(d[7:0]); else m_error = 1;
         32'd16: m_rate = (d[15:0] < 16'd2) ? 16'd2 : d[15:0];
         32'd20: if (d != 0) begin
                    rxq.delete(); txq.delete(); m_error = 0;
                    @(negedge clk);
                 end
         32'd24: m_fc = (d != 0);
         default: ;
      endcase
   endtask

   task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] e);
      logic [31:0] d;
      bus_read(a, d);
      check(tag, d, e);
   endtask

   task automatic rd_rx_data(input string tag);
      logic [31:0] d, e;
      e = '0;
      if (rxq.size() != 0) e = {24'h0, rxq.pop_front()};
      m_avail = 0;
      bus_read(32'd0, d);
      check(tag, d, e);
   endtask

   task automatic rd_rx_state(input string tag);
      logic [31:0] d, e;
      e = {26'h0, m_err, m_avail, 4'(rxq.size())};
      m_err = 0;
      bus_read(32'd8, d);
      check(tag, d, e);
   endtask

   function automatic logic [31:0] tx_state_word(input logic idle, input int unsigned cnt);
      return {m_rate, 11'h0, idle, 4'(cnt)};
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int unsigned bc);
      @(negedge clk) rx = 1'b0;
      repeat (bc - 1) @(negedge clk);
      for (int unsigned i = 0; i < 8; i++) begin
         @(negedge clk) rx = b[i];
         repeat (bc - 1) @(negedge clk);
      end
      @(negedge clk) rx = stop_ok;
      repeat (bc - 1) @(negedge clk);
      @(negedge clk) rx = 1'b1;
      repeat (3 * bc) @(negedge clk);
      if (stop_ok) begin
         m_avail = 1;
         if (rxq.size() < 8) rxq.push_back(b); else m_error = 1;
      end else begin
         m_err = 1;
      end
   endtask

   // Records one frame as seen on tx, one sample per clock from the start edge.
   task automatic tx_capture(input int unsigned r, output logic [7:0] b, output logic stop,
                             output int unsigned lowrun, output logic timeout);
      logic samp[$];
      int unsigned w = 0;
      timeout = 0; b = '0; stop = 0; lowrun = 0;
      while (tx !== 1'b0 && w < 3000) begin @(negedge clk); w++; end
      if (tx !== 1'b0) begin timeout = 1; return; end
      for (int unsigned i = 0; i < 10 * r; i++) begin samp.push_back(tx); @(negedge clk); end
      while (lowrun < samp.size() && samp[lowrun] == 1'b0) lowrun++;
      for (int unsigned k = 0; k < 8; k++) b[k] = samp[(k + 1) * r + r / 2];
      stop = samp[9 * r + r / 2];
   endtask

   initial begin
      logic [7:0]  b, rb;
      logic        stop, to;
      int unsigned lowrun, lows, r;

      nReset = 1'b1; rx = 1'b1; cts = 1'b0; wen = 1'b0; ren = 1'b0;
      addr = '0; wdata = '0; strobe = 4'hF;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_tx", tx, 1'b1);
      check("reset_rdata", rdata, '0);
      nReset = 1'b0;
      @(negedge clk);
      check("reset_rts", rts, 1'b0);
      check("reset_error", error, 1'b0);
      check("request_stall", request_stall, 1'b0);
      rd_expect("reset_tx_state", 32'd12, tx_state_word(1'b1, 0));
      rd_rx_state("reset_rx_state");

      // Transmit path, held off by cts and then released.
      r = $urandom_range(4, 10);
      reg_write(32'd16, r);
      reg_write(32'd24, 32'h0F);
      reg_write(32'd4, 32'h55);
      lows = 0;
      repeat (40) begin @(negedge clk); if (tx !== 1'b1) lows++; end
      check("tx_held_by_cts", lows, 0);
      rd_expect("tx_state_pending", 32'd12, tx_state_word(1'b1, 1));
      reg_write(32'd24, 32'h0);
      tx_capture(m_rate, b, stop, lowrun, to);
      check("tx55_timeout", to, 1'b0);
      check("tx55_byte", b, txq.pop_front());
      check("tx55_start_len", lowrun, m_rate);
      check("tx55_stop", stop, 1'b1);

      reg_write(32'd24, 32'h1);
      reg_write(32'd4, $urandom_range(0, 255));
      reg_write(32'd4, $urandom_range(0, 255));
      rd_expect("tx_state_two", 32'd12, tx_state_word(1'b1, 2));
      @(negedge clk) cts = 1'b1;
      for (int unsigned i = 0; i < 2; i++) begin
         tx_capture(m_rate, b, stop, lowrun, to);
         check("txr_timeout", to, 1'b0);
         check("txr_byte", b, (txq.size() != 0) ? txq.pop_front() : 8'hXX);
         check("txr_stop", stop, 1'b1);
      end
      cts = 1'b0;
      rd_expect("tx_state_drained", 32'd12, tx_state_word(1'b1, 0));

      // Abort a frame in flight by writing TX_STATE.
      reg_write(32'd24, 32'h0);
      reg_write(32'd4, $urandom_range(0, 255));
      repeat (m_rate + 2) @(negedge clk);
      rd_expect("tx_busy", 32'd12, tx_state_word(1'b0, 0));
      reg_write(32'd12, 32'h0);
      void'(txq.pop_front());
      check("tx_abort_line", tx, 1'b1);
      rd_expect("tx_abort_idle", 32'd12, tx_state_word(1'b1, 0));

      // Receive path at 4 cycles per bit.
      reg_write(32'd16, 32'd4);
      send_frame(8'hA5, 1'b1, 4);
      rd_rx_state("rx_a5_state");
      rd_rx_data("rx_a5_data");
      rd_rx_state("rx_a5_after");
      for (int unsigned i = 0; i < 4; i++) begin
         rb = 8'($urandom_range(0, 255));
         send_frame(rb, ($urandom_range(0, 3) != 0), 4);
         rd_rx_state("rx_rand_state");
         rd_rx_data("rx_rand_data");
      end
      send_frame(8'($urandom_range(0, 255)), 1'b0, 4);
      rd_rx_state("rx_badstop_state");
      rd_rx_state("rx_badstop_cleared");
      @(negedge clk) rx = 1'b0;
      @(negedge clk) rx = 1'b1;
      repeat (20) @(negedge clk);
      rd_rx_state("rx_glitch");
      rd_expect("rate_four", 32'd12, tx_state_word(1'b1, 0));

      // Fill the RX FIFO past capacity.
      for (int unsigned i = 0; i < 9; i++) begin
         send_frame(8'($urandom_range(0, 255)), 1'b1, 4);
         check("rts_level", rts, (rxq.size() == 8));
         check("error_level", error, m_error);
      end
      rd_rx_state("rx_full_state");
      rd_rx_data("rx_full_head");
      check("rts_after_pop", rts, 1'b0);
      reg_write(32'd20, 32'h1);
      check("clear_rts", rts, 1'b0);
      check("clear_error", error, 1'b0);
      rd_rx_state("clear_rx_state");
      rd_rx_data("rx_empty_read");
      rd_rx_state("rx_avail_cleared");

      // TX FIFO overflow with flow control blocking.
      reg_write(32'd24, 32'h1);
      for (int unsigned i = 0; i < 9; i++) reg_write(32'd4, $urandom_range(0, 255));
      rd_expect("tx_full_state", 32'd12, tx_state_word(1'b1, 8));
      check("tx_overflow_error", error, m_error);
      check("tx_blocked_line", tx, 1'b1);
      reg_write(32'd20, 32'h1);
      rd_expect("tx_cleared_state", 32'd12, tx_state_word(1'b1, 0));
      check("tx_cleared_error", error, 1'b0);

      // Divisor clamp and unmapped accesses.
      reg_write(32'd16, 32'd1);
      rd_expect("rate_clamp_1", 32'd12, tx_state_word(1'b1, 0));
      reg_write(32'd16, 32'd0);
      rd_expect("rate_clamp_0", 32'd12, tx_state_word(1'b1, 0));
      reg_write(32'd28, $urandom);
      rd_expect("unmapped_read", 32'd28, 32'd0);
      rd_expect("unmapped_write", 32'd12, tx_state_word(1'b1, 0));
      @(negedge clk);
      check("rdata_idle", rdata, 32'd0);

      // Reset in the middle of a frame.
      reg_write(32'd16, 32'd8);
      reg_write(32'd24, 32'h0);
      reg_write(32'd4, $urandom_range(0, 255));
      repeat (12) @(negedge clk);
      nReset = 1'b1;
      model_reset();
      @(negedge clk);
      check("midreset_tx", tx, 1'b1);
      check("midreset_error", error, 1'b0);
      check("midreset_rdata", rdata, 32'd0);
      nReset = 1'b0;
      rd_expect("midreset_tx_state", 32'd12, tx_state_word(1'b1, 0));
      rd_rx_state("midreset_rx_state");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
